riscv_v_issue: RTL and testbench
================================

Name: riscv_v_issue

Overview:
- Vector issue/operand-read stage directly upstream of riscv_v_bypass.
- Accepts decoded vector instructions and blocks RAW/WAW hazards with a per-register scoreboard.
- Reads vs1/vs2 from the synchronous-read VRF and registers srca, srcb, integer_data and is_scalar_int for the bypass/execute stage.
- Uses a valid/ready handshake on both sides and a 2-deep internal pipeline (R stage, O stage), so back-pressure never loses VRF read data.

Parameters:
- NUM_VREGS, 32, number of architectural vector registers (scoreboard bits).
- VREG_AW, 5, vector register address width, equal to $clog2(NUM_VREGS).
- OP_W, 8, width of the opaque decoded-op field passed through to execute.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- dec_valid  in  1  decoded instruction valid
- dec_ready  out  1  issue accepts this cycle
- dec_vs1, dec_vs2, dec_vd  in  VREG_AW  source and destination vector registers
- dec_uses_vs1, dec_uses_vs2, dec_writes_vd  in  1  operand/destination usage flags
- dec_is_scalar_int  in  1  srca comes from the scalar integer register
- dec_integer_data  in  riscv_data_t  scalar operand value
- dec_op  in  OP_W  decoded operation
- vrf_raddr_a, vrf_raddr_b  out  VREG_AW  VRF read addresses; data returns next cycle
- vrf_rdata_a, vrf_rdata_b  in  riscv_v_data_t  VRF read data
- ex_valid  out  1  O stage holds a valid instruction
- ex_ready  in  1  execute consumes the instruction
- ex_srca, ex_srcb  out  riscv_v_data_t  vector operands, feeding bypass srca/srcb
- ex_integer_data  out  riscv_data_t  feeds bypass integer_data
- ex_is_scalar_int  out  1  feeds bypass is_scalar_int
- ex_vd  out  VREG_AW  destination register
- ex_writes_vd  out  1  destination write flag
- ex_op  out  OP_W  decoded operation
- wb_valid  in  1  writeback retires a destination
- wb_vd  in  VREG_AW  register whose scoreboard bit is cleared
- flush  in  1  squash all instructions held in R and O

Behaviour:
- Reset (synchronous, active-high rst): R/O valid = 0, scoreboard = 0, hold flag = 0, all ex_* outputs = 0.
- Hazard:
  - hz = (uses_vs1 && !is_scalar_int && sb[vs1]) || (uses_vs2 && sb[vs2]) || (writes_vd && sb[vd]).
  - Scoreboard bits are registered; wb_valid in the same cycle does not unblock (no same-cycle bypass).
- Ready: dec_ready = !rst && !flush && !hz && (!R_valid || R_advance). Accept = dec_valid && dec_ready.
- VRF addressing: vrf_raddr_a/b = dec_vs1/dec_vs2 combinationally, every cycle.
- On accept (cycle T):
  - Metadata latched into R at T+1.
  - sb[vd] set if writes_vd.
- R stage (T+1):
  - VRF data is valid only in the first R cycle.
  - If O is empty or ex_ready, R_advance: O <= R plus rdata.
  - Else R captures rdata into hold registers, sets hold flag, and uses the held data on later cycles.
  - hold flag clears when R advances.
- Scalar operands: when is_scalar_int, srca in O = 0 (rdata_a ignored). When !uses_vs2, srcb = 0.
- O stage: ex_* stay stable while ex_valid && !ex_ready. Minimum latency is accept at T -> ex_valid at T+2. Full throughput is 1/cycle with ex_ready held high.
- Writeback: wb_valid clears sb[wb_vd]. If set and clear hit the same index in one cycle, set wins (cannot occur legally).
- Flush:
  - R_valid and O_valid go to 0 next cycle; hold flag cleared.
  - Scoreboard bits of squashed R/O instructions that had writes_vd are cleared.
  - No accept during the flush cycle.
  - wb clears in the same cycle still apply.
- Reset mid-operation: everything returns to reset values next cycle; in-flight VRF data is discarded.

Decomposition:
- riscv_v_pkg holds:
  - riscv_v_vreg_addr_t (VREG_AW bits)
  - riscv_v_issue_pkt_t struct (srca, srcb, integer_data, is_scalar_int, vd, writes_vd, op)
  - RISCV_V_NUM_VREGS constant
- Sub-module riscv_v_scoreboard: set/clear vector with 3 query ports returning the hazard bit.
- R/O pipeline logic stays in riscv_v_issue.

Test Plan:
- Back-to-back independent: ops vd=1,2,3 with vs disjoint, ex_ready=1 -> ex_valid at T+2, T+3, T+4; srca/srcb equal to VRF contents of vs1/vs2.
- RAW stall: op A vd=5, then op B vs2=5 -> dec_ready=0 until the cycle after wb_valid with wb_vd=5; B issues with sb[5] set again only if B writes v5.
- Back-pressure: ex_ready=0 for 4 cycles with R full, VRF changing rdata each cycle -> ex_srca/ex_srcb stable; R data equals the value read at T+1; no loss or duplication after release.
- Scalar: dec_is_scalar_int=1, integer_data=32'hFFFF_FF80, sb[vs1] set -> no stall; ex_srca=0, ex_integer_data=32'hFFFF_FF80, ex_is_scalar_int=1.
- Flush: R and O both valid (vd=7, vd=8) plus flush -> ex_valid=0 next cycle; sb[7]=sb[8]=0; an op with vs1=7 issues immediately.
- Reset mid-stall: rst asserted with O held and sb nonzero -> next cycle ex_valid=0, all sb=0, dec_ready=1.

Source files
------------

// File: rtl/riscv_v_pkg.sv
// Shared types for the vector issue/operand-read slice.
package riscv_v_pkg;
  localparam int RISCV_V_NUM_VREGS = 32;
  localparam int RISCV_V_VREG_AW   = $clog2(RISCV_V_NUM_VREGS);
  localparam int RISCV_V_VLEN      = 128;
  localparam int RISCV_XLEN        = 32;
  localparam int RISCV_V_OP_W      = 8;

  typedef logic [RISCV_XLEN-1:0]      riscv_data_t;
  typedef logic [RISCV_V_VLEN-1:0]    riscv_v_data_t;
  typedef logic [RISCV_V_VREG_AW-1:0] riscv_v_vreg_addr_t;
  typedef logic [RISCV_V_OP_W-1:0]    riscv_v_op_t;

  // R stage metadata; operand data arrives from the VRF a cycle later
  typedef struct packed {
    riscv_data_t        integer_data;
    logic               is_scalar_int;
    logic               uses_vs2;
    riscv_v_vreg_addr_t vd;
    logic               writes_vd;
    riscv_v_op_t        op;
  } riscv_v_r_meta_t;

  typedef struct packed {
    riscv_v_data_t      srca;
    riscv_v_data_t      srcb;
    riscv_data_t        integer_data;
    logic               is_scalar_int;
    riscv_v_vreg_addr_t vd;
    logic               writes_vd;
    riscv_v_op_t        op;
  } riscv_v_issue_pkt_t;
endpackage

// File: rtl/riscv_v_scoreboard.sv
// Per-register pending-write bits with NQ hazard query ports.
module riscv_v_scoreboard #(
  parameter int NUM_VREGS = 32,
  parameter int VREG_AW   = 5,
  parameter int NQ        = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       set_en,
  input  logic [VREG_AW-1:0]         set_idx,
  input  logic [NUM_VREGS-1:0]       clr_mask,
  input  logic [NQ-1:0]              q_en,
  input  logic [NQ-1:0][VREG_AW-1:0] q_idx,
  output logic [NQ-1:0]              q_hit
);
  logic [NUM_VREGS-1:0] sb, set_mask;

  always_comb begin
    set_mask = '0;
    set_mask[set_idx] = set_en;
  end

  // set is applied after clear so it wins on a shared index
  always_ff @(posedge clk) begin
    if (rst) sb <= '0;
    else     sb <= (sb & ~clr_mask) | set_mask;
  end

  for (genvar g = 0; g < NQ; g++) begin : g_q
    assign q_hit[g] = q_en[g] && sb[q_idx[g]];
  end
endmodule

// File: rtl/riscv_v_issue.sv
// Vector issue stage: scoreboard hazard check, VRF read (R) and operand register (O).
module riscv_v_issue
  import riscv_v_pkg::*;
#(
  parameter int NUM_VREGS = RISCV_V_NUM_VREGS,
  parameter int VREG_AW   = RISCV_V_VREG_AW,
  parameter int OP_W      = RISCV_V_OP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec_valid,
  output logic               dec_ready,
  input  logic [VREG_AW-1:0] dec_vs1,
  input  logic [VREG_AW-1:0] dec_vs2,
  input  logic [VREG_AW-1:0] dec_vd,
  input  logic               dec_uses_vs1,
  input  logic               dec_uses_vs2,
  input  logic               dec_writes_vd,
  input  logic               dec_is_scalar_int,
  input  riscv_data_t        dec_integer_data,
  input  logic [OP_W-1:0]    dec_op,
  output logic [VREG_AW-1:0] vrf_raddr_a,
  output logic [VREG_AW-1:0] vrf_raddr_b,
  input  riscv_v_data_t      vrf_rdata_a,
  input  riscv_v_data_t      vrf_rdata_b,
  output logic               ex_valid,
  input  logic               ex_ready,
  output riscv_v_data_t      ex_srca,
  output riscv_v_data_t      ex_srcb,
  output riscv_data_t        ex_integer_data,
  output logic               ex_is_scalar_int,
  output logic [VREG_AW-1:0] ex_vd,
  output logic               ex_writes_vd,
  output logic [OP_W-1:0]    ex_op,
  input  logic               wb_valid,
  input  logic [VREG_AW-1:0] wb_vd,
  input  logic               flush
);
  logic                       r_valid, r_hold, o_valid;
  riscv_v_r_meta_t            r_meta;
  riscv_v_data_t              hold_a, hold_b, src_a, src_b;
  riscv_v_issue_pkt_t         o_pkt, r_pkt;
  logic                       o_free, r_adv, hz, accept;
  logic [2:0]                 q_en, q_hit;
  logic [2:0][VREG_AW-1:0]    q_idx;
  logic [NUM_VREGS-1:0]       clr_mask;

  assign vrf_raddr_a = dec_vs1;
  assign vrf_raddr_b = dec_vs2;

  assign q_en  = {dec_writes_vd, dec_uses_vs2, dec_uses_vs1 && !dec_is_scalar_int};
  assign q_idx = {dec_vd, dec_vs2, dec_vs1};
  assign hz    = |q_hit;

  assign o_free    = !o_valid || ex_ready;
  assign r_adv     = r_valid && o_free;
  assign dec_ready = !rst && !flush && !hz && (!r_valid || r_adv);
  assign accept    = dec_valid && dec_ready;

  // squashed writers release their scoreboard bits alongside any retiring wb
  always_comb begin
    clr_mask = '0;
    if (wb_valid) clr_mask[wb_vd] = 1'b1;
    if (flush) begin
      if (r_valid && r_meta.writes_vd) clr_mask[r_meta.vd] = 1'b1;
      if (o_valid && o_pkt.writes_vd)  clr_mask[o_pkt.vd]  = 1'b1;
    end
  end

  riscv_v_scoreboard #(.NUM_VREGS(NUM_VREGS), .VREG_AW(VREG_AW), .NQ(3)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (accept && dec_writes_vd),
    .set_idx  (dec_vd),
    .clr_mask (clr_mask),
    .q_en     (q_en),
    .q_idx    (q_idx),
    .q_hit    (q_hit)
  );

  // VRF data is only live in the first R cycle; afterwards use the held copy
  assign src_a = r_hold ? hold_a : vrf_rdata_a;
  assign src_b = r_hold ? hold_b : vrf_rdata_b;

  always_comb begin
    r_pkt.srca          = r_meta.is_scalar_int ? '0 : src_a;
    r_pkt.srcb          = r_meta.uses_vs2 ? src_b : '0;
    r_pkt.integer_data  = r_meta.integer_data;
    r_pkt.is_scalar_int = r_meta.is_scalar_int;
    r_pkt.vd            = r_meta.vd;
    r_pkt.writes_vd     = r_meta.writes_vd;
    r_pkt.op            = r_meta.op;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_hold  <= 1'b0;
      o_valid <= 1'b0;
      r_meta  <= '0;
      hold_a  <= '0;
      hold_b  <= '0;
      o_pkt   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_hold  <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      if (o_free) begin
        o_valid <= r_valid;
        if (r_valid) o_pkt <= r_pkt;
      end
      if (r_adv) r_hold <= 1'b0;
      else if (r_valid && !r_hold) begin
        r_hold <= 1'b1;
        hold_a <= vrf_rdata_a;
        hold_b <= vrf_rdata_b;
      end
      if (!r_valid || r_adv) begin
        r_valid <= accept;
        if (accept)
          r_meta <= '{integer_data: dec_integer_data, is_scalar_int: dec_is_scalar_int,
                      uses_vs2: dec_uses_vs2, vd: dec_vd, writes_vd: dec_writes_vd, op: dec_op};
      end
    end
  end

  assign ex_valid         = o_valid;
  assign ex_srca          = o_pkt.srca;
  assign ex_srcb          = o_pkt.srcb;
  assign ex_integer_data  = o_pkt.integer_data;
  assign ex_is_scalar_int = o_pkt.is_scalar_int;
  assign ex_vd            = o_pkt.vd;
  assign ex_writes_vd     = o_pkt.writes_vd;
  assign ex_op            = o_pkt.op;
endmodule

// File: tb/tb_riscv_v_issue.sv
// Bench for riscv_v_issue: directed scenarios plus random traffic against a queue/scoreboard model.
module tb_riscv_v_issue;
  import riscv_v_pkg::*;

  logic clk = 1'b0, rst = 1'b1;
  logic dec_valid = 0, dec_uses_vs1 = 0, dec_uses_vs2 = 0, dec_writes_vd = 0, dec_is_scalar_int = 0;
  logic [4:0] dec_vs1 = 0, dec_vs2 = 0, dec_vd = 0, wb_vd = 0;
  logic [31:0] dec_integer_data = 0;
  logic [7:0] dec_op = 0;
  logic ex_ready = 0, wb_valid = 0, flush = 0;
  logic dec_ready, ex_valid, ex_is_scalar_int, ex_writes_vd;
  logic [4:0] vrf_raddr_a, vrf_raddr_b, ex_vd;
  logic [127:0] vrf_rdata_a, vrf_rdata_b, ex_srca, ex_srcb;
  logic [31:0] ex_integer_data;
  logic [7:0] ex_op;

  riscv_v_issue dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_vs1(dec_vs1), .dec_vs2(dec_vs2), .dec_vd(dec_vd),
    .dec_uses_vs1(dec_uses_vs1), .dec_uses_vs2(dec_uses_vs2), .dec_writes_vd(dec_writes_vd),
    .dec_is_scalar_int(dec_is_scalar_int), .dec_integer_data(dec_integer_data), .dec_op(dec_op),
    .vrf_raddr_a(vrf_raddr_a), .vrf_raddr_b(vrf_raddr_b),
    .vrf_rdata_a(vrf_rdata_a), .vrf_rdata_b(vrf_rdata_b),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_srca(ex_srca), .ex_srcb(ex_srcb),
    .ex_integer_data(ex_integer_data), .ex_is_scalar_int(ex_is_scalar_int),
    .ex_vd(ex_vd), .ex_writes_vd(ex_writes_vd), .ex_op(ex_op),
    .wb_valid(wb_valid), .wb_vd(wb_vd), .flush(flush)
  );

  always #5 clk = ~clk;

  // synchronous-read register file model
  logic [127:0] vrf_mem [32];
  always @(posedge clk) begin
    vrf_rdata_a <= vrf_mem[vrf_raddr_a];
    vrf_rdata_b <= vrf_mem[vrf_raddr_b];
  end

  typedef struct {
    logic [127:0] a, b;
    logic [31:0]  idata;
    logic         sc, wv;
    logic [4:0]   vd;
    logic [7:0]   op;
    int           t;
  } exp_t;

  exp_t       q[$];
  logic [4:0] retire[$];
  bit         ref_sb[32];
  int         cyc = 0, checks = 0, failures = 0;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: check at negedge against the model, then advance the model at posedge
  task automatic step();
    logic hz, exp_rdy, exp_v, acc, out;
    exp_t e;
    @(negedge clk);
    hz = (dec_uses_vs1 && !dec_is_scalar_int && ref_sb[dec_vs1]) ||
         (dec_uses_vs2 && ref_sb[dec_vs2]) || (dec_writes_vd && ref_sb[dec_vd]);
    exp_rdy = !rst && !flush && !hz && (q.size() < 2 || ex_ready);
    exp_v = (q.size() > 0) && (q[0].t + 2 <= cyc);
    chk("dec_ready", dec_ready, exp_rdy);
    chk("ex_valid", ex_valid, exp_v);
    chk("raddr_a", vrf_raddr_a, dec_vs1);
    chk("raddr_b", vrf_raddr_b, dec_vs2);
    if (exp_v) begin
      chk("ex_srca", ex_srca, q[0].a);
      chk("ex_srcb", ex_srcb, q[0].b);
      chk("ex_integer_data", ex_integer_data, q[0].idata);
      chk("ex_is_scalar_int", ex_is_scalar_int, q[0].sc);
      chk("ex_vd", ex_vd, q[0].vd);
      chk("ex_writes_vd", ex_writes_vd, q[0].wv);
      chk("ex_op", ex_op, q[0].op);
    end
    acc = dec_valid && exp_rdy;
    out = exp_v && ex_ready;
    e.a = dec_is_scalar_int ? 128'd0 : vrf_mem[dec_vs1];
    e.b = dec_uses_vs2 ? vrf_mem[dec_vs2] : 128'd0;
    e.idata = dec_integer_data; e.sc = dec_is_scalar_int; e.wv = dec_writes_vd;
    e.vd = dec_vd; e.op = dec_op; e.t = cyc;
    @(posedge clk);
    if (rst) begin
      q.delete(); retire.delete();
      foreach (ref_sb[i]) ref_sb[i] = 0;
    end else if (flush) begin
      foreach (q[i]) if (q[i].wv) ref_sb[q[i].vd] = 0;
      q.delete();
      if (wb_valid) ref_sb[wb_vd] = 0;
    end else begin
      if (out) begin
        if (q[0].wv) retire.push_back(q[0].vd);
        void'(q.pop_front());
      end
      if (wb_valid) ref_sb[wb_vd] = 0;
      if (acc) begin
        q.push_back(e);
        if (e.wv) ref_sb[e.vd] = 1;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic issue(input logic [4:0] vs1, vs2, vd, input logic u1, u2, wv, sc,
                       input logic [31:0] idata, input logic [7:0] op);
    dec_valid = 1; dec_vs1 = vs1; dec_vs2 = vs2; dec_vd = vd;
    dec_uses_vs1 = u1; dec_uses_vs2 = u2; dec_writes_vd = wv; dec_is_scalar_int = sc;
    dec_integer_data = idata; dec_op = op;
  endtask

  task automatic idle();
    dec_valid = 0; dec_uses_vs1 = 0; dec_uses_vs2 = 0; dec_writes_vd = 0; dec_is_scalar_int = 0;
  endtask

  task automatic check_ex_zero(input string tag);
    chk({tag, "_srca"}, ex_srca, 0);
    chk({tag, "_srcb"}, ex_srcb, 0);
    chk({tag, "_idata"}, ex_integer_data, 0);
    chk({tag, "_vd"}, ex_vd, 0);
    chk({tag, "_op"}, ex_op, 0);
  endtask

  // drain the pipe and retire every outstanding destination, bounded
  task automatic retire_all();
    idle();
    ex_ready = 1;
    for (int k = 0; k < 40 && (q.size() > 0 || retire.size() > 0); k++) begin
      if (retire.size() > 0) begin wb_valid = 1; wb_vd = retire.pop_front(); end
      else wb_valid = 0;
      step();
    end
    wb_valid = 0;
    chk("drain_bound", q.size() + retire.size(), 0);
  endtask

  initial begin
    foreach (vrf_mem[i]) vrf_mem[i] = rnd128();
    @(posedge clk); @(posedge clk); #1;

    // reset state
    step(); step();
    rst = 0;
    check_ex_zero("reset");
    step();

    // back-to-back independent
    ex_ready = 1;
    issue(10, 11, 1, 1, 1, 1, 0, 32'h0, 8'h01); step();
    issue(12, 13, 2, 1, 1, 1, 0, 32'h0, 8'h02); step();
    issue(14, 15, 3, 1, 1, 1, 0, 32'h0, 8'h03); step();
    idle(); repeat (3) step();
    retire_all();

    // RAW stall on v5 until the cycle after its writeback
    issue(16, 17, 5, 1, 1, 1, 0, 32'h0, 8'h11); step();
    issue(18, 5, 6, 1, 1, 1, 0, 32'h0, 8'h12); repeat (4) step();
    wb_valid = 1; wb_vd = 5;
    for (int k = 0; k < retire.size(); k++) if (retire[k] == 5) retire.delete(k);
    step();
    wb_valid = 0; step();
    idle(); repeat (3) step();
    retire_all();

    // back-pressure with VRF contents changing every cycle
    ex_ready = 0;
    issue(20, 21, 10, 1, 1, 1, 0, 32'h0, 8'h21); step();
    issue(22, 23, 11, 1, 1, 1, 0, 32'h0, 8'h22); step();
    idle();
    repeat (5) begin
      foreach (vrf_mem[i]) vrf_mem[i] = rnd128();
      dec_vs1 = 5'($urandom); dec_vs2 = 5'($urandom);
      step();
    end
    ex_ready = 1; repeat (4) step();
    retire_all();

    // scalar operand bypasses the vs1 hazard; no vs2 means srcb is zero
    ex_ready = 0;
    issue(24, 25, 20, 1, 1, 1, 0, 32'h0, 8'h31); step();
    issue(20, 26, 21, 1, 0, 1, 1, 32'hFFFF_FF80, 8'h32); step();
    idle(); ex_ready = 1; repeat (4) step();
    retire_all();

    // flush with R and O both occupied
    ex_ready = 0;
    issue(1, 2, 7, 1, 1, 1, 0, 32'h0, 8'h41); step();
    issue(3, 4, 8, 1, 1, 1, 0, 32'h0, 8'h42); step();
    idle(); step();
    flush = 1; step();
    flush = 0;
    issue(7, 8, 12, 1, 1, 1, 0, 32'h0, 8'h43); step();
    idle(); ex_ready = 1; repeat (3) step();
    retire_all();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      ex_ready = ($urandom % 4) != 0;
      issue(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), ($urandom % 4) == 0, $urandom, 8'($urandom));
      dec_valid = ($urandom % 3) != 0;
      if (retire.size() > 0 && ($urandom % 3) == 0) begin
        int idx;
        idx = int'($urandom_range(retire.size() - 1));
        wb_valid = 1; wb_vd = retire[idx]; retire.delete(idx);
      end else wb_valid = 0;
      vrf_mem[$urandom % 32] = rnd128();
      step();
    end
    wb_valid = 0;
    retire_all();

    // reset while stalled with scoreboard bits set
    ex_ready = 0;
    issue(1, 2, 13, 1, 1, 1, 0, 32'h0, 8'h51); step();
    issue(3, 4, 14, 1, 1, 1, 0, 32'h0, 8'h52); step();
    idle(); step();
    rst = 1; step();
    rst = 0;
    check_ex_zero("midrst");
    issue(13, 14, 13, 1, 1, 1, 0, 32'h0, 8'h53); step();
    idle(); ex_ready = 1; repeat (3) step();
    retire_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
